// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct values, ALU codes and mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct field to ALU operation code.
// Also flags whether the funct is one this core supports.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_legal
);

    // Map funct to ALU op; unsupported codes fall back to ADD
    always_comb begin
        alu_control = ALU_ADD;
        funct_legal = 1'b1;
        unique case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath, with
// run/halt gating, completion pulse and retired counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_control,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [3:0]  state
);

    state_t     state_q;
    state_t     state_d;
    logic       pc_write;
    logic       branch;
    logic [3:0] rtype_alu;
    logic       funct_legal;
    logic       op_legal;

    mips_alu_decoder u_alu_dec (
        .funct       (funct),
        .alu_control (rtype_alu),
        .funct_legal (funct_legal)
    );

    assign op_legal = (opcode == OP_LW)   ||
                      (opcode == OP_SW)   ||
                      (opcode == OP_BEQ)  ||
                      (opcode == OP_ADDI) ||
                      (opcode == OP_J)    ||
                      ((opcode == OP_RTYPE) && funct_legal);

    assign pc_en = pc_write | (branch & zero);
    assign state = state_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Retired-instruction counter, bumped on each completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             retired <= '0;
        else if (instr_done) retired <= retired + 32'd1;
    end

    // Next-state and Moore outputs for the current state
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        pc_src      = PCSRC_ALU;
        alu_control = ALU_AND;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b   = SRCB_IMM_SH;
                alu_control = ALU_ADD;
                if (!op_legal) begin
                    illegal = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                state_d     = (opcode == OP_LW) ? S_MEMREAD
                                                : S_MEMWRITE;
            end
            S_MEMREAD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_MEMWRITE: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_REG;
                alu_control = rtype_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PCSRC_ALUOUT;
                branch      = 1'b1;
                instr_done  = 1'b1;
                state_d     = run ? S_FETCH : S_IDLE;
            end
            S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed and
// random instruction streams against a per-instruction step model.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_en;
    logic        iord;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic [3:0]  alu_control;
    logic        instr_done;
    logic        illegal;
    logic [31:0] retired;
    logic [3:0]  state;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .retired     (retired),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs_cw;
    assign obs_cw = {iord, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, pc_src,
                     alu_control, instr_done, illegal};

    int n_cmp = 0;
    int n_bad = 0;
    int model_ret = 0;

    logic [16:0] exp_cw[$];
    bit          exp_pw[$];
    bit          exp_br[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, obs, want, $time);
        end
    endtask

    function automatic logic [16:0] cw(
        input bit io, input bit mw, input bit irw, input bit rd,
        input bit m2r, input bit rw, input bit asa,
        input logic [1:0] asb, input logic [1:0] ps,
        input logic [3:0] alu, input bit done, input bit ill);
        return {io, mw, irw, rd, m2r, rw, asa, asb, ps, alu,
                done, ill};
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h2A: return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op,
                                    input logic [5:0] fn);
        if (op == 6'h00) return alu_of(fn) != 4'b1111;
        return op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h08 || op == 6'h02;
    endfunction

    task automatic push(input logic [16:0] c, input bit pw,
                        input bit br);
        exp_cw.push_back(c);
        exp_pw.push_back(pw);
        exp_br.push_back(br);
    endtask

    // Expected control word per cycle, from FETCH to the last step
    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        bit lg;
        lg = is_legal(op, fn);
        exp_cw.delete(); exp_pw.delete(); exp_br.delete();
        push(cw(0,0,1,0,0,0,0,2'b01,2'b00,4'b0010,0,0), 1, 0);
        push(cw(0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0,!lg), 0, 0);
        if (lg) begin
            case (op)
                6'h23: begin
                    push(cw(0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0,0),0,0);
                    push(cw(1,0,0,0,0,0,0,2'b00,2'b00,4'b0000,0,0),0,0);
                    push(cw(0,0,0,0,1,1,0,2'b00,2'b00,4'b0000,1,0),0,0);
                end
                6'h2B: begin
                    push(cw(0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0,0),0,0);
                    push(cw(1,1,0,0,0,0,0,2'b00,2'b00,4'b0000,1,0),0,0);
                end
                6'h00: begin
                    push(cw(0,0,0,0,0,0,1,2'b00,2'b00,alu_of(fn),0,0),
                         0,0);
                    push(cw(0,0,0,1,0,1,0,2'b00,2'b00,4'b0000,1,0),0,0);
                end
                6'h04:
                    push(cw(0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,1,0),0,1);
                6'h08: begin
                    push(cw(0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0,0),0,0);
                    push(cw(0,0,0,0,0,1,0,2'b00,2'b00,4'b0000,1,0),0,0);
                end
                default:
                    push(cw(0,0,0,0,0,0,0,2'b00,2'b10,4'b0000,1,0),1,0);
            endcase
        end
    endtask

    // Hold IDLE n cycles checking quiet outputs, then restart
    task automatic idle_hold(input int n);
        for (int k = 0; k < n; k++) begin
            chk("idle_cw", 32'(obs_cw), 32'd0);
            zero = 1'b1;
            #1;
            chk("idle_pc_en", 32'(pc_en), 32'd0);
            if (k == n - 1) run = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Run one instruction starting in FETCH; run drops from step
    // drop_at onward (negative = never); zf<0 means random zero
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int drop_at, input int zf);
        int n;
        build(op, fn);
        opcode = op;
        funct  = fn;
        n = exp_cw.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("cw op%h fn%h s%0d", op, fn, i),
                32'(obs_cw), 32'(exp_cw[i]));
            zero = (zf < 0) ? 1'($urandom) : 1'(zf);
            #1;
            chk($sformatf("pc_en op%h s%0d", op, i), 32'(pc_en),
                32'(exp_pw[i] | (exp_br[i] & zero)));
            run = (drop_at >= 0 && i >= drop_at) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        if (is_legal(op, fn)) model_ret++;
        chk("retired", retired, 32'(model_ret));
        if (!run) idle_hold(2 + int'($urandom_range(0, 2)));
    endtask

    logic [5:0] ops[7] = '{6'h00, 6'h02, 6'h04, 6'h08,
                           6'h23, 6'h2B, 6'h3F};
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int drop;
        rst = 1'b1; run = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        #3;
        chk("reset_cw", 32'(obs_cw), 32'd0);
        chk("reset_retired", retired, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_run", 32'(obs_cw), 32'd0);
        run = 1'b1;
        @(posedge clk); #1;

        run_instr(6'h23, 6'h04, -1, -1);
        run_instr(6'h00, 6'h20, -1, -1);
        run_instr(6'h00, 6'h22, -1, -1);
        run_instr(6'h04, 6'h11, -1, 1);
        run_instr(6'h04, 6'h11, -1, 0);
        run_instr(6'h3F, 6'h20, -1, -1);
        run_instr(6'h00, 6'h03, -1, -1);
        run_instr(6'h2B, 6'h00, -1, -1);
        run_instr(6'h08, 6'h2A, -1, -1);
        run_instr(6'h02, 6'h25, -1, -1);
        run_instr(6'h00, 6'h24, 2, -1);
        run_instr(6'h08, 6'h00, 0, -1);
        run_instr(6'h3F, 6'h00, 1, -1);

        for (int t = 0; t < 60; t++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            fn = fns[$urandom_range(0, 4)];
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
            drop = ($urandom_range(0, 5) == 0)
                   ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, fn, drop, -1);
        end

        // Asynchronous reset in the middle of a lw
        opcode = 6'h23; funct = 6'h04;
        repeat (3) @(posedge clk);
        #1;
        chk("memread_cw", 32'(obs_cw),
            32'(cw(1,0,0,0,0,0,0,2'b00,2'b00,4'b0000,0,0)));
        #2 rst = 1'b1; zero = 1'b1;
        #1;
        chk("midrst_cw", 32'(obs_cw), 32'd0);
        chk("midrst_pc_en", 32'(pc_en), 32'd0);
        chk("midrst_retired", retired, 32'd0);
        model_ret = 0;
        @(posedge clk); #1;
        chk("held_rst_cw", 32'(obs_cw), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_instr(6'h23, 6'h04, -1, -1);
        run_instr(6'h00, 6'h2A, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
